trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 151 +++++++++++++++
 tb/tb_trace_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer
//   Retirement trace capture buffer with a PC trigger and a post-trigger window.
//   Retiring instructions whose class is enabled in cfg_class_mask are written
//   into a circular array while the block is ARMED or in POST. A retire at
//   cfg_trig_pc, or a stop pulse, moves ARMED to POST. POST then records a
//   further post_left entries, or ends early on stop, and the block settles in
//   DONE. An arm pulse clears the buffer and starts a new capture from any
//   state.
//
// Ports
//   clk            : system clock; all state changes on its rising edge
//   reset          : asynchronous, active-low reset
//   ret_valid      : one instruction retires this cycle
//   ret_pc         : PC of the retiring instruction
//   ret_instr      : raw instruction; class is [3:0]
//   ret_wdata      : value written to rd, or 0 if none
//   cfg_class_mask : bit k records class k (k = 0..6); bit 7 records classes 7..15
//   cfg_trig_pc    : trigger PC
//   cfg_post       : post-trigger entry count; 0 selects POST_DEFAULT
//   arm            : pulse that clears the buffer and starts capture
//   stop           : pulse that forces a trigger (ARMED) or ends capture (POST)
//   rd_en, rd_idx  : read request; index 0 is the oldest valid entry
//   rd_data        : {pc, instr, wdata} of the entry read, one cycle after rd_en
//   rd_valid       : rd_data holds a valid entry
//   state          : 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count          : number of valid entries, saturating at DEPTH

module trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int POST_DEFAULT = DEPTH / 2,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ret_valid,
  input  logic [31:0]   ret_pc,
  input  logic [31:0]   ret_instr,
  input  logic [31:0]   ret_wdata,
  input  logic [7:0]    cfg_class_mask,
  input  logic [31:0]   cfg_trig_pc,
  input  logic [AW-1:0] cfg_post,
  input  logic          arm,
  input  logic          stop,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [95:0]   rd_data,
  output logic          rd_valid,
  output logic [1:0]    state,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   post_left_q;

  logic [95:0]   mem [DEPTH];

  logic [3:0]    op_class;
  logic          class_en;
  logic          capturing;
  logic          rec;
  logic          trig_hit;
  logic [AW:0]   post_load;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;

  assign op_class  = ret_instr[3:0];
  // Classes 7..15 are undefined and share a single enable bit.
  assign class_en  = (op_class < 4'd7) ? cfg_class_mask[op_class[2:0]]
                                       : cfg_class_mask[7];
  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
  // arm restarts the capture, so a retire in the same cycle is discarded
  // rather than landing in the buffer that is being cleared.
  assign rec       = ret_valid && class_en && capturing && !arm;
  assign trig_hit  = rec && (ret_pc == cfg_trig_pc);
  assign post_load = (cfg_post == '0) ? (AW+1)'(POST_DEFAULT) : {1'b0, cfg_post};

  // Oldest entry sits at wr_ptr - count. Only the low AW bits of count matter
  // since the arithmetic wraps modulo DEPTH (count == DEPTH maps to 0).
  assign rd_addr     = wr_ptr_q - count_q[AW-1:0] + rd_idx;
  assign rd_in_range = ({1'b0, rd_idx} < count_q);

  // Capture FSM, write pointer, fill count and post-trigger counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_left_q <= '0;
    end else begin
      if (rec) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q != (AW+1)'(DEPTH)) count_q <= count_q + 1'b1;
      end

      if (arm) begin
        // arm wins over stop and restarts from any state.
        state_q     <= S_ARMED;
        wr_ptr_q    <= '0;
        count_q     <= '0;
        post_left_q <= post_load;
      end else begin
        case (state_q)
          S_ARMED: begin
            // The triggering record itself does not consume post_left.
            if (stop || trig_hit) state_q <= S_POST;
          end
          S_POST: begin
            if (rec) begin
              if (post_left_q != '0) post_left_q <= post_left_q - 1'b1;
              if (post_left_q <= (AW+1)'(1)) state_q <= S_DONE;
            end
            if (stop) state_q <= S_DONE;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  // Trace storage: one write port, one read port, no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (rec) mem[wr_ptr_q] <= {ret_pc, ret_instr, ret_wdata};
  end

  // Read handshake: rd_en sampled at edge N presents rd_data at N+1 with
  // rd_valid high only when rd_idx addressed a valid entry; there is no
  // backpressure. The non-blocking read returns the pre-write contents when
  // the slot is written in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en && rd_in_range;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  assign state = state_q;
  assign count = count_q;

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic          ret_valid;
  logic [31:0]   ret_pc;
  logic [31:0]   ret_instr;
  logic [31:0]   ret_wdata;
  logic [7:0]    cfg_class_mask;
  logic [31:0]   cfg_trig_pc;
  logic [AW-1:0] cfg_post;
  logic          arm;
  logic          stop;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [95:0]   rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [AW:0]   count;

  trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ret_valid      (ret_valid),
    .ret_pc         (ret_pc),
    .ret_instr      (ret_instr),
    .ret_wdata      (ret_wdata),
    .cfg_class_mask (cfg_class_mask),
    .cfg_trig_pc    (cfg_trig_pc),
    .cfg_post       (cfg_post),
    .arm            (arm),
    .stop           (stop),
    .rd_en          (rd_en),
    .rd_idx         (rd_idx),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .state          (state),
    .count          (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks_total;
  int checks_passed;

  localparam logic [31:0] I_ALU = 32'h0012_3101;  // class 1
  localparam logic [31:0] I_BR0 = 32'h0050_0006;  // op 0x06, branch
  localparam logic [31:0] I_ALR = 32'h0070_2101;  // op 0x01, ALU-I
  localparam logic [31:0] I_BR1 = 32'h0090_0016;  // op 0x16, branch

  function automatic logic [31:0] wd(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [95:0] ent(input logic [31:0] pc, input logic [31:0] instr);
    return {pc, instr, wd(pc)};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change #1 after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_wdata = wd(pc);
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic retire_read(input logic [31:0] pc, input logic [31:0] instr,
                             input logic [AW-1:0] idx);
    ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_wdata = wd(pc);
    rd_en = 1'b1; rd_idx = idx;
    tick();
    ret_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] idx);
    rd_en = 1'b1; rd_idx = idx; tick(); rd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks_total = 0; checks_passed = 0;
    reset = 1'b0; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_wdata = '0;
    cfg_class_mask = 8'hFF; cfg_trig_pc = '0; cfg_post = '0;
    arm = 1'b0; stop = 1'b0; rd_en = 1'b0; rd_idx = '0;

    #12;
    check("rst_state", 96'(state), 96'd0);
    check("rst_count", 96'(count), 96'd0);
    check("rst_rd_valid", 96'(rd_valid), 96'd0);
    check("rst_rd_data", rd_data, 96'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // Trigger at 0x40 with 3 post entries, wrapping the buffer.
    cfg_class_mask = 8'hFF; cfg_trig_pc = 32'h40; cfg_post = 4'd3;
    do_arm();
    check("arm_state", 96'(state), 96'd1);
    check("arm_count", 96'(count), 96'd0);
    for (int k = 0; k <= 20; k++) begin
      if (k == 16) begin
        // Full buffer: idx 0 is the slot being overwritten by PC 0x40.
        retire_read(32'(k * 4), I_ALU, 4'd0);
        check("rw_same_slot_data", rd_data, ent(32'h0, I_ALU));
        check("rw_same_slot_valid", 96'(rd_valid), 96'd1);
        check("trig_state", 96'(state), 96'd2);
      end else begin
        retire(32'(k * 4), I_ALU);
      end
      if (k == 4)  check("count_5", 96'(count), 96'd5);
      if (k == 18) check("post_state", 96'(state), 96'd2);
      if (k == 19) check("done_state", 96'(state), 96'd3);
    end
    check("wrap_count", 96'(count), 96'd16);
    check("wrap_state", 96'(state), 96'd3);
    read(4'd0);
    check("wrap_idx0", rd_data, ent(32'h10, I_ALU));
    check("wrap_idx0_valid", 96'(rd_valid), 96'd1);
    read(4'd15);
    check("wrap_idx15", rd_data, ent(32'h4C, I_ALU));

    // Branches only.
    cfg_class_mask = 8'h40; cfg_trig_pc = 32'h999;
    do_arm();
    check("rearm_state", 96'(state), 96'd1);
    check("rearm_count", 96'(count), 96'd0);
    retire(32'h100, I_BR0);
    retire(32'h104, I_ALR);
    retire(32'h108, I_BR1);
    check("mask_count", 96'(count), 96'd2);
    read(4'd0);
    check("mask_idx0", rd_data, ent(32'h100, I_BR0));
    read(4'd1);
    check("mask_idx1", rd_data, ent(32'h108, I_BR1));
    read(4'd2);
    check("rd_idx_eq_count", 96'(rd_valid), 96'd0);

    // Stop without trigger, stop again, then no further capture.
    cfg_class_mask = 8'hFF;
    do_arm();
    retire(32'h200, I_ALU);
    check("armed_count1", 96'(count), 96'd1);
    do_stop();
    check("stop_to_post", 96'(state), 96'd2);
    do_stop();
    check("stop_to_done", 96'(state), 96'd3);
    retire(32'h204, I_ALU);
    check("done_no_record", 96'(count), 96'd1);
    read(4'd0);
    check("done_idx0", rd_data, ent(32'h200, I_ALU));

    // Five entries, read, then asynchronous reset during POST.
    cfg_trig_pc = 32'h200; cfg_post = 4'd3;
    do_arm();
    for (int k = 0; k < 5; k++) retire(32'h300 + 32'(k * 4), I_ALU);
    check("five_count", 96'(count), 96'd5);
    check("five_state", 96'(state), 96'd1);
    read(4'd0);
    check("five_idx0", rd_data, ent(32'h300, I_ALU));
    check("five_idx0_valid", 96'(rd_valid), 96'd1);
    read(4'd5);
    check("five_idx5_valid", 96'(rd_valid), 96'd0);
    do_stop();
    retire(32'h314, I_ALU);
    retire(32'h318, I_ALU);
    check("seven_count", 96'(count), 96'd7);
    check("seven_state", 96'(state), 96'd2);
    reset = 1'b0;
    #2;
    check("async_rst_state", 96'(state), 96'd0);
    check("async_rst_count", 96'(count), 96'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    retire(32'h31C, I_ALU);
    check("idle_no_record", 96'(count), 96'd0);
    check("idle_state", 96'(state), 96'd0);

    // arm and stop together from DONE.
    do_arm();
    retire(32'h400, I_ALU);
    do_stop();
    do_stop();
    check("pre_both_state", 96'(state), 96'd3);
    arm = 1'b1; stop = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0;
    check("arm_stop_state", 96'(state), 96'd1);
    check("arm_stop_count", 96'(count), 96'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
